// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 8-bit data / 16-bit instruction datapath.
// Fetches and latches each instruction, then sequences the datapath strobes one phase at a time.
module multicycle_controller #(
    parameter int unsigned IWIDTH = 16,
    parameter int unsigned CWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IWIDTH-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic              imem_req,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              zero,
    output logic [IWIDTH-1:0] instr,
    output logic              memtoreg,
    output logic              alusrc,
    output logic              regdst,
    output logic              regwrite,
    output logic              jump,
    output logic              pcsrc,
    output logic [2:0]        alucontrol,
    output logic              pc_en,
    output logic              halted,
    output logic              illegal,
    output logic [CWIDTH-1:0] retired
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;
    localparam logic [2:0] S_ILLEGAL = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [IWIDTH-1:0] instr_q, instr_d;
    logic [CWIDTH-1:0] retired_q, retired_d;

    logic [3:0] opcode;
    logic [2:0] funct;
    logic       op_r, op_lw, op_sw, op_beq, op_addi, op_j, op_halt;
    logic       funct_ok;

    assign opcode   = instr_q[IWIDTH-1 -: 4];
    assign funct    = instr_q[2:0];
    assign op_r     = (opcode == 4'd0);
    assign op_lw    = (opcode == 4'd1);
    assign op_sw    = (opcode == 4'd2);
    assign op_beq   = (opcode == 4'd3);
    assign op_addi  = (opcode == 4'd4);
    assign op_j     = (opcode == 4'd5);
    assign op_halt  = (opcode == 4'd15);
    assign funct_ok = (funct == 3'b010) || (funct == 3'b110) || (funct == 3'b000) ||
                      (funct == 3'b001) || (funct == 3'b111);

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        memtoreg   = 1'b0;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        jump       = 1'b0;
        pcsrc      = 1'b0;
        alucontrol = 3'b000;
        pc_en      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_j) begin
                    jump    = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end else if (op_halt) begin
                    state_d = S_HALT;
                end else if (op_r || op_lw || op_sw || op_beq || op_addi) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (op_r) begin
                    if (funct_ok) begin
                        alucontrol = funct;
                        state_d    = S_WB;
                    end else begin
                        state_d = S_ILLEGAL;
                    end
                end else if (op_lw || op_sw || op_addi) begin
                    alusrc     = 1'b1;
                    alucontrol = 3'b010;
                    state_d    = op_addi ? S_WB : S_MEM;
                end else if (op_beq) begin
                    alucontrol = 3'b110;
                    pcsrc      = zero;
                    pc_en      = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = op_sw;
                alusrc     = 1'b1;
                alucontrol = 3'b010;
                if (dmem_ready) begin
                    if (op_sw) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pc_en    = 1'b1;
                state_d  = S_FETCH;
                // ALU controls stay driven so aluout is stable while it is written back.
                if (op_r) begin
                    regdst     = 1'b1;
                    alucontrol = funct;
                end else if (op_lw) begin
                    memtoreg   = 1'b1;
                    alusrc     = 1'b1;
                    alucontrol = 3'b010;
                end else begin
                    alusrc     = 1'b1;
                    alucontrol = 3'b010;
                end
            end
            S_HALT:    state_d = S_HALT;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_ILLEGAL;
        endcase
    end

    assign retired_d = retired_q + CWIDTH'(pc_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Gated by reset so a fetch in flight is abandoned the moment reset rises.
    assign imem_req = (state_q == S_FETCH) && !reset;
    assign instr    = instr_q;
    assign halted   = (state_q == S_HALT);
    assign illegal  = (state_q == S_ILLEGAL);
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic        dmem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        zero;
    logic [15:0] instr;
    logic        memtoreg, alusrc, regdst, regwrite, jump, pcsrc;
    logic [2:0]  alucontrol;
    logic        pc_en;
    logic        halted;
    logic        illegal;
    logic [7:0]  retired;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.IWIDTH(16), .CWIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .zero       (zero),
        .instr      (instr),
        .memtoreg   (memtoreg),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .jump       (jump),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pc_en      (pc_en),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; imem_rdata = '0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;

        // During reset
        cyc(); #1;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_retired", retired, 0);
        chk("rst_instr", instr, 16'h0000);

        // R-type add, zero wait: FETCH DECODE EXEC WB
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h0642; #1;
        chk("r_fetch_req", imem_req, 1);
        chk("r_fetch_pc_en", pc_en, 0);
        chk("r_fetch_regwrite", regwrite, 0);
        cyc(); imem_ready = 1'b0; #1;
        chk("r_dec_instr", instr, 16'h0642);
        chk("r_dec_req", imem_req, 0);
        chk("r_dec_pc_en", pc_en, 0);
        cyc(); #1;
        chk("r_exec_alu", alucontrol, 3'b010);
        chk("r_exec_regwrite", regwrite, 0);
        chk("r_exec_pc_en", pc_en, 0);
        cyc(); #1;
        chk("r_wb_regwrite", regwrite, 1);
        chk("r_wb_regdst", regdst, 1);
        chk("r_wb_pc_en", pc_en, 1);
        chk("r_wb_alu", alucontrol, 3'b010);
        cyc(); #1;
        chk("r_retired", retired, 1);
        chk("r_back_fetch", imem_req, 1);

        // LW with dmem_ready delayed 3 cycles: 8 cycles total
        imem_ready = 1'b1; imem_rdata = 16'h1500;
        cyc(); imem_ready = 1'b0; #1;
        chk("lw_dec_dmem_req", dmem_req, 0);
        cyc(); #1;
        chk("lw_exec_alusrc", alusrc, 1);
        chk("lw_exec_alu", alucontrol, 3'b010);
        chk("lw_exec_dmem_req", dmem_req, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("lw_mem_wait_req", dmem_req, 1);
            chk("lw_mem_wait_we", dmem_we, 0);
            chk("lw_mem_wait_pc_en", pc_en, 0);
        end
        cyc(); dmem_ready = 1'b1; #1;
        chk("lw_mem_last_req", dmem_req, 1);
        chk("lw_mem_last_pc_en", pc_en, 0);
        cyc(); dmem_ready = 1'b0; #1;
        chk("lw_wb_memtoreg", memtoreg, 1);
        chk("lw_wb_regwrite", regwrite, 1);
        chk("lw_wb_alusrc", alusrc, 1);
        chk("lw_wb_pc_en", pc_en, 1);
        chk("lw_wb_dmem_req", dmem_req, 0);
        cyc(); #1;
        chk("lw_retired", retired, 2);
        chk("lw_back_fetch", imem_req, 1);

        // BEQ taken then not taken: 3 cycles each
        imem_ready = 1'b1; imem_rdata = 16'h3004; zero = 1'b1;
        cyc(); imem_ready = 1'b0; #1;
        chk("beq1_dec_pc_en", pc_en, 0);
        cyc(); #1;
        chk("beq1_pcsrc", pcsrc, 1);
        chk("beq1_pc_en", pc_en, 1);
        chk("beq1_alu", alucontrol, 3'b110);
        cyc(); #1;
        chk("beq1_fetch", imem_req, 1);
        chk("beq1_retired", retired, 3);
        imem_ready = 1'b1; zero = 1'b0;
        cyc(); imem_ready = 1'b0; #1;
        cyc(); #1;
        chk("beq0_pcsrc", pcsrc, 0);
        chk("beq0_pc_en", pc_en, 1);
        cyc(); #1;
        chk("beq0_fetch", imem_req, 1);
        chk("beq0_retired", retired, 4);

        // SW zero wait: retires out of MEM
        imem_ready = 1'b1; imem_rdata = 16'h2000;
        cyc(); imem_ready = 1'b0; #1;
        cyc(); #1;
        chk("sw_exec_pc_en", pc_en, 0);
        cyc(); dmem_ready = 1'b1; #1;
        chk("sw_mem_req", dmem_req, 1);
        chk("sw_mem_we", dmem_we, 1);
        chk("sw_mem_pc_en", pc_en, 1);
        chk("sw_mem_regwrite", regwrite, 0);
        cyc(); dmem_ready = 1'b0; #1;
        chk("sw_fetch", imem_req, 1);
        chk("sw_retired", retired, 5);

        // ADDI: WB with alusrc=1, regdst=0
        imem_ready = 1'b1; imem_rdata = 16'h4000;
        cyc(); imem_ready = 1'b0; #1;
        cyc(); #1;
        chk("addi_exec_alusrc", alusrc, 1);
        chk("addi_exec_dmem_req", dmem_req, 0);
        cyc(); #1;
        chk("addi_wb_regwrite", regwrite, 1);
        chk("addi_wb_regdst", regdst, 0);
        chk("addi_wb_alusrc", alusrc, 1);
        chk("addi_wb_memtoreg", memtoreg, 0);
        cyc(); #1;
        chk("addi_retired", retired, 6);

        // J: retires in DECODE
        imem_ready = 1'b1; imem_rdata = 16'h5020;
        cyc(); imem_ready = 1'b0; #1;
        chk("j_jump", jump, 1);
        chk("j_pc_en", pc_en, 1);
        chk("j_regwrite", regwrite, 0);
        cyc(); #1;
        chk("j_next_fetch", imem_req, 1);
        chk("j_retired", retired, 7);

        // Illegal opcode 7: sticky, stray readies ignored
        imem_ready = 1'b1; imem_rdata = 16'h7000;
        cyc(); #1;
        chk("ill_dec_flag", illegal, 0);
        chk("ill_dec_pc_en", pc_en, 0);
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("ill_flag", illegal, 1);
            chk("ill_no_ireq", imem_req, 0);
            chk("ill_no_dreq", dmem_req, 0);
            chk("ill_retired", retired, 7);
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;

        // Asynchronous reset pulse mid-cycle
        cyc(); reset = 1'b1; #1;
        chk("arst_illegal", illegal, 0);
        chk("arst_ireq", imem_req, 0);
        chk("arst_retired", retired, 0);
        cyc(); reset = 1'b0; #1;
        chk("arst_resume_fetch", imem_req, 1);

        // 256 zero-wait J instructions wrap retired to 0
        for (int i = 0; i < 256; i++) begin
            cyc(); imem_ready = 1'b1; imem_rdata = 16'h5020;
            cyc(); imem_ready = 1'b0; #1;
            if (i == 255) begin
                chk("wrap_before", retired, 255);
                chk("wrap_pc_en", pc_en, 1);
            end
        end
        cyc(); #1;
        chk("wrap_retired", retired, 0);

        // HALT: sticky, not counted
        imem_ready = 1'b1; imem_rdata = 16'hF000;
        cyc(); imem_ready = 1'b0; #1;
        chk("halt_dec_flag", halted, 0);
        chk("halt_dec_pc_en", pc_en, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); imem_ready = 1'b1; #1;
            chk("halt_flag", halted, 1);
            chk("halt_no_ireq", imem_req, 0);
            chk("halt_pc_en", pc_en, 0);
            chk("halt_retired", retired, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
